// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// access-owner codes and counter widths.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Holds MEM_LAT-1 for MEM_LAT up to 4.
    localparam int LAT_CNT_W = 2;
    // Holds STARVE_MAX up to 15.
    localparam int STARVE_W  = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant decision between CPU and debug, with the starvation counter that forces
// a debug grant after STARVE_MAX consecutive CPU wins over a waiting debug request.
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic dbg_req,
    output logic gnt_dbg
);

    logic [STARVE_W-1:0] starve_cnt;

    assign gnt_dbg = dbg_req && (!cpu_req || (starve_cnt == STARVE_W'(STARVE_MAX)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (arb_en && (cpu_req || dbg_req)) begin
            if (gnt_dbg) begin
                starve_cnt <= '0;
            end else if (dbg_req && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and the debug port.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
//
// state | meaning
// IDLE  | arbitrate; latch winner's we/addr/wdata
// ISSUE | one-cycle memory strobe
// WAIT  | MEM_LAT cycles on a down-counter; read data captured on the last
// DONE  | completion cycle for the owner
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_stall_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          dbg_rvalid_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_stall_cyc_o,
    output logic [15:0]   perf_dbg_acc_o
`endif
);

    arb_state_t           state_q, state_d;
    logic                 owner_q;
    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q;
    logic [DW-1:0]        rdata_q;
    logic [LAT_CNT_W-1:0] lat_cnt_q;
    logic                 arb_en;
    logic                 any_req;
    logic                 gnt_dbg;

    assign arb_en  = (state_q == IDLE);
    assign any_req = cpu_req_i | dbg_req_i;

    dmem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .arb_en  (arb_en),
        .cpu_req (cpu_req_i),
        .dbg_req (dbg_req_i),
        .gnt_dbg (gnt_dbg)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lat_cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (arb_en && any_req) begin
                owner_q <= gnt_dbg ? OWN_DBG : OWN_CPU;
                we_q    <= gnt_dbg ? dbg_we_i : cpu_we_i;
                addr_q  <= gnt_dbg ? dbg_addr_i : cpu_addr_i;
                wdata_q <= gnt_dbg ? dbg_wdata_i : cpu_wdata_i;
            end
            if (state_q == ISSUE) begin
                lat_cnt_q <= LAT_CNT_W'(MEM_LAT - 1);
            end else if ((state_q == WAIT) && (lat_cnt_q != '0)) begin
                lat_cnt_q <= lat_cnt_q - 1'b1;
            end
            // Writes must not disturb the last read value.
            if ((state_q == WAIT) && (lat_cnt_q == '0) && !we_q) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_en_o     = (state_q == ISSUE);
    assign mem_we_o     = (state_q == ISSUE) && we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign dbg_gnt_o    = (state_q == ISSUE) && (owner_q == OWN_DBG);
    assign dbg_rvalid_o = (state_q == DONE) && (owner_q == OWN_DBG);
    assign cpu_rdata_o  = rdata_q;
    assign dbg_rdata_o  = rdata_q;
    assign cpu_stall_o  = !rst_i && cpu_req_i && !((state_q == DONE) && (owner_q == OWN_CPU));

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_cyc_o <= '0;
            perf_dbg_acc_o   <= '0;
        end else begin
            if (cpu_stall_o && (perf_stall_cyc_o != '1)) begin
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            end
            if (dbg_rvalid_o && (perf_dbg_acc_o != '1)) begin
                perf_dbg_acc_o <= perf_dbg_acc_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model with
// randomized CPU/debug traffic, plus a directed MEM_LAT=3 instance.
module tb_dmem_arbiter;

    localparam int L    = 1;
    localparam int LB   = 3;
    localparam int SMAX = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        cpu_req_b, cpu_we_b, cpu_stall_b, dbg_gnt_b, dbg_rvalid_b;
    logic [31:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b, dbg_rdata_b;
    logic        mem_en_b, mem_we_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall, perf_stall_b;
    logic [15:0] perf_dbg, perf_dbg_b;
`endif

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rdata_o(dbg_rdata), .dbg_rvalid_o(dbg_rvalid),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_stall_cyc_o(perf_stall), .perf_dbg_acc_o(perf_dbg)
`endif
    );

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LB), .STARVE_MAX(SMAX)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_b), .cpu_we_i(cpu_we_b), .cpu_addr_i(cpu_addr_b), .cpu_wdata_i(cpu_wdata_b),
        .cpu_rdata_o(cpu_rdata_b), .cpu_stall_o(cpu_stall_b),
        .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'd0), .dbg_wdata_i(32'd0),
        .dbg_gnt_o(dbg_gnt_b), .dbg_rdata_o(dbg_rdata_b), .dbg_rvalid_o(dbg_rvalid_b),
        .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
        .mem_rdata_i(mem_rdata_b)
`ifdef DMEM_ARB_PERF_EN
        , .perf_stall_cyc_o(perf_stall_b), .perf_dbg_acc_o(perf_dbg_b)
`endif
    );

    // Fixed-latency memories: read data appears exactly MEM_LAT cycles after the
    // strobe; any other cycle returns garbage.
    logic [31:0] mem_a [16];
    logic [31:0] pipe_a [L];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_b [LB];

    always @(posedge clk_i) begin
        if (mem_en && mem_we) mem_a[mem_addr[5:2]] <= mem_wdata;
        pipe_a[0] <= (mem_en && !mem_we) ? mem_a[mem_addr[5:2]] : $urandom;
        for (int k = 1; k < L; k++) pipe_a[k] <= pipe_a[k-1];
    end
    assign mem_rdata = pipe_a[L-1];

    always @(posedge clk_i) begin
        if (mem_en_b && mem_we_b) mem_b[mem_addr_b[5:2]] <= mem_wdata_b;
        pipe_b[0] <= (mem_en_b && !mem_we_b) ? mem_b[mem_addr_b[5:2]] : $urandom;
        for (int k = 1; k < LB; k++) pipe_b[k] <= pipe_b[k-1];
    end
    assign mem_rdata_b = pipe_b[LB-1];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          next_idle, issue_c, done_c, starve;
    bit          own_dbg, t_we;
    logic [31:0] t_addr, t_wdata, last_rd;
    logic [31:0] ref_mem [16];
    bit          cpu_done_now, dbg_done_now;
    bit          grant_log [$];
    int          dbg_done_cnt = 0;
    int          perf_stall_exp = 0;
    int          perf_dbg_exp = 0;
    int          lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Inputs for the current cycle are already driven; predict and check it.
    task automatic eval_cycle();
        bit exp_en, is_done, exp_stall;
        cpu_done_now = 1'b0;
        dbg_done_now = 1'b0;
        if (rst_i) begin
            next_idle = cyc + 1;
            issue_c = -1;
            done_c = -1;
            starve = 0;
            last_rd = '0;
            perf_stall_exp = 0;
            perf_dbg_exp = 0;
            @(negedge clk_i);
            chk("rst_stall",  32'(cpu_stall),  32'd0);
            chk("rst_mem_en", 32'(mem_en),     32'd0);
            chk("rst_mem_we", 32'(mem_we),     32'd0);
            chk("rst_gnt",    32'(dbg_gnt),    32'd0);
            chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
            chk("rst_rdata",  cpu_rdata,       32'd0);
            chk("rst_addr",   mem_addr,        32'd0);
            return;
        end
        if (cyc == next_idle) begin
            if (cpu_req || dbg_req) begin
                own_dbg = dbg_req && (!cpu_req || starve == SMAX);
                if (own_dbg) begin
                    t_we = dbg_we; t_addr = dbg_addr; t_wdata = dbg_wdata;
                    starve = 0;
                end else begin
                    t_we = cpu_we; t_addr = cpu_addr; t_wdata = cpu_wdata;
                    if (dbg_req && starve < SMAX) starve++;
                end
                issue_c = cyc + 1;
                done_c = cyc + 2 + L;
                next_idle = cyc + 3 + L;
                grant_log.push_back(own_dbg);
            end else begin
                next_idle = cyc + 1;
            end
        end
        exp_en = (cyc == issue_c);
        is_done = (cyc == done_c);
        if (is_done) begin
            if (t_we) ref_mem[t_addr[5:2]] = t_wdata;
            else last_rd = ref_mem[t_addr[5:2]];
        end
        exp_stall = cpu_req && !(is_done && !own_dbg);
        @(negedge clk_i);
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        chk("mem_we", 32'(mem_we), 32'(exp_en && t_we));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(exp_en && own_dbg));
        if (exp_en) begin
            chk("mem_addr", mem_addr, t_addr);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(is_done && own_dbg));
        chk("cpu_rdata", cpu_rdata, last_rd);
        chk("dbg_rdata", dbg_rdata, last_rd);
        if (is_done) begin
            cpu_done_now = !own_dbg;
            dbg_done_now = own_dbg;
            if (own_dbg) begin
                dbg_done_cnt++;
                perf_dbg_exp++;
            end
        end
        if (exp_stall) perf_stall_exp++;
    endtask

    task automatic wait_done(input bit for_dbg, output int n);
        n = 0;
        while (!(for_dbg ? dbg_done_now : cpu_done_now) && n < 40) begin
            next_cycle();
            eval_cycle();
            n++;
        end
        chk(for_dbg ? "dbg_done_seen" : "cpu_done_seen",
            32'(for_dbg ? dbg_done_now : cpu_done_now), 32'd1);
    endtask

    task automatic cpu_access(input bit we, input logic [31:0] a, input logic [31:0] d, output int n);
        next_cycle();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        eval_cycle();
        wait_done(1'b0, n);
        next_cycle();
        cpu_req = 1'b0;
        eval_cycle();
    endtask

    task automatic dbg_access(input bit we, input logic [31:0] a, input logic [31:0] d, output int n);
        next_cycle();
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        eval_cycle();
        wait_done(1'b1, n);
        next_cycle();
        dbg_req = 1'b0;
        eval_cycle();
    endtask

    // Requesters drop in the cycle after their completion and may re-request
    // (with new fields) at once; p_* is the percent chance of raising when idle.
    task automatic drive_cycle(input int p_cpu, input int p_dbg);
        if (cpu_req && cpu_done_now) cpu_req = 1'b0;
        if (dbg_req && dbg_done_now) dbg_req = 1'b0;
        if (!cpu_req && $urandom_range(99) < p_cpu) begin
            cpu_req = 1'b1;
            cpu_we = 1'($urandom_range(1));
            cpu_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
            cpu_wdata = $urandom;
        end
        if (!dbg_req && $urandom_range(99) < p_dbg) begin
            dbg_req = 1'b1;
            dbg_we = 1'($urandom_range(1));
            dbg_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
            dbg_wdata = $urandom;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst_i = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hAB;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_addr_b = '0; cpu_wdata_b = '0;

        repeat (2) begin
            next_cycle();
            eval_cycle();
        end
        next_cycle();
        rst_i = 1'b0;
        eval_cycle();
        wait_done(1'b0, lat);
        chk("first_wr_lat", lat, 2 + L);
        next_cycle();
        cpu_req = 1'b0;
        eval_cycle();

        cpu_access(1'b0, 32'h10, 32'h0, lat);
        chk("cpu_rd_lat", lat, 2 + L);
        chk("cpu_rd_val", cpu_rdata, 32'hAB);

        n0 = dbg_done_cnt;
        dbg_access(1'b1, 32'h8, 32'h5, lat);
        dbg_access(1'b0, 32'h8, 32'h0, lat);
        chk("dbg_rd_val", dbg_rdata, 32'h5);
        chk("dbg_pulses", dbg_done_cnt - n0, 2);

        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        eval_cycle();
        next_cycle();
        eval_cycle();
        next_cycle();
        rst_i = 1'b1;
        eval_cycle();
        next_cycle();
        rst_i = 1'b0;
        eval_cycle();
        wait_done(1'b0, lat);
        chk("restart_lat", lat, 2 + L);
        chk("restart_rd", cpu_rdata, 32'hAB);
        next_cycle();
        cpu_req = 1'b0;
        eval_cycle();

        for (int i = 0; i < 16; i++) dbg_access(1'b1, 32'(i * 4), $urandom, lat);

        grant_log.delete();
        for (int i = 0; i < 300 && grant_log.size() < 12; i++) begin
            next_cycle();
            drive_cycle(100, 100);
            eval_cycle();
        end
        chk("starve_grants", 32'(grant_log.size() >= 12), 32'd1);
        for (int i = 0; i < 12 && i < grant_log.size(); i++)
            chk($sformatf("grant_order%0d", i), 32'(grant_log[i]), 32'(i % 5 == 4));
        repeat (20) begin
            next_cycle();
            drive_cycle(0, 0);
            eval_cycle();
        end

        repeat (500) begin
            next_cycle();
            drive_cycle(60, 25);
            eval_cycle();
        end
        repeat (20) begin
            next_cycle();
            drive_cycle(0, 0);
            eval_cycle();
        end

        next_cycle();
        cpu_req_b = 1'b1; cpu_we_b = 1'b1; cpu_addr_b = 32'h4; cpu_wdata_b = 32'h1234;
        eval_cycle();
        chk("b_wr_t0_stall", 32'(cpu_stall_b), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 6) cpu_req_b = 1'b0;
            eval_cycle();
            chk($sformatf("b_wr_en%0d", k), 32'(mem_en_b), 32'(k == 1));
            chk($sformatf("b_wr_we%0d", k), 32'(mem_we_b), 32'(k == 1));
            chk($sformatf("b_wr_stall%0d", k), 32'(cpu_stall_b), 32'(k < 5));
            chk($sformatf("b_wr_rdata%0d", k), cpu_rdata_b, 32'd0);
        end
        next_cycle();
        cpu_req_b = 1'b1; cpu_we_b = 1'b0;
        eval_cycle();
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 6) cpu_req_b = 1'b0;
            eval_cycle();
            chk($sformatf("b_rd_en%0d", k), 32'(mem_en_b), 32'(k == 1));
            chk($sformatf("b_rd_stall%0d", k), 32'(cpu_stall_b), 32'(k < 5));
            chk($sformatf("b_rd_rdata%0d", k), cpu_rdata_b, (k >= 5) ? 32'h1234 : 32'd0);
        end

`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall", perf_stall, perf_stall_exp);
        chk("perf_dbg", 32'(perf_dbg), perf_dbg_exp);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
